uart_cmd_dispatch: RTL and testbench
====================================

Name: uart_cmd_dispatch

Overview:
- Consumes the 64-bit validated frames produced by the UART receive/address-filter stage (data/data_valid, already GA-filtered).
- Buffers the frames in a small FIFO, checks header and checksum, and executes write and read commands on a simple register bus with an ack handshake and a timeout.
- Returns one 64-bit response frame per executed command to the downstream UART TX packer.

Parameters:
- DEPTH, 4: FIFO depth in frames; must be a power of 2, minimum 2.
- ACK_TIMEOUT, 255: maximum number of cycles spent in REQ waiting for I_reg_ack; range 2..65535.

Ports:
- I_clk_10M, input, 1: system clock, 10 MHz.
- I_rst, input, 1: asynchronous reset, active-high.
- I_data, input, 64: frame from the receive stage.
- I_data_valid, input, 1: one-cycle strobe; I_data is valid in that cycle.
- O_reg_wr, output, 1: register write request, held until ack or timeout.
- O_reg_rd, output, 1: register read request, held until ack or timeout.
- O_reg_addr, output, 8: register address.
- O_reg_wdata, output, 32: write data.
- I_reg_ack, input, 1: register bus acknowledge.
- I_reg_rdata, input, 32: read data; valid while I_reg_ack is high.
- O_resp_data, output, 64: response frame.
- O_resp_valid, output, 1: response valid.
- I_resp_ready, input, 1: downstream accepts the response.
- O_err_cnt, output, 8: saturating count of bad frames and timeouts.
- O_ovf_cnt, output, 8: saturating count of frames dropped because the FIFO was full.

Behaviour:
- Reset: I_rst is the only clock/reset in this block: one clock, asynchronous active-high reset. Asserting it clears the FIFO (count 0), sets the state to IDLE, and drives every output to 0. Reset mid-command aborts the command; no response is issued.
- Frame format:
  - [63:56] header, 0xA5.
  - [55:48] opcode: 0x01 = write, 0x02 = read.
  - [47:40] address.
  - [39:8] payload.
  - [7:0] checksum = XOR of bytes [63:56] through [15:8].
- FIFO push: I_data is written on I_data_valid when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
- FIFO overflow: otherwise the frame is dropped and O_ovf_cnt increments, saturating at 255.
- FIFO pointers wrap modulo DEPTH. Count is visible to the FSM the cycle after the push.
- IDLE: if count > 0, latch the head frame into the holding register, pop it, and go to CHECK.
- CHECK (1 cycle):
  - Header != 0xA5, checksum mismatch, or opcode not in {0x01, 0x02}: O_err_cnt +1 (saturating), no bus access, no response, go to IDLE.
  - Otherwise go to REQ.
- REQ:
  - Drive O_reg_addr and O_reg_wdata from the held frame; O_reg_wr = 1 for opcode 0x01, O_reg_rd = 1 for opcode 0x02.
  - A timeout counter starts at 0 on entry and increments each cycle.
  - I_reg_ack high: capture I_reg_rdata (0 for writes), set status = opcode | 0x80, deassert the request the next cycle, go to RESP.
  - Counter reaches ACK_TIMEOUT-1 without ack: status = 0xFF, rdata = 0, O_err_cnt +1, go to RESP.
  - Ack and timeout in the same cycle: ack wins.
- RESP:
  - O_resp_valid = 1 with O_resp_data = {0x5A, status, addr, rdata, chk}, where chk = XOR of the preceding 7 bytes.
  - O_resp_data is held stable until I_resp_ready is sampled high while valid; the handshake completes that cycle and the next state is IDLE.
- Latency: I_data_valid at cycle 0 into an empty FIFO in IDLE gives pop at cycle 1, CHECK at cycle 2, and request asserted at cycle 3. With ack at cycle 3, O_resp_valid rises at cycle 4.
- One command is in flight at a time. Frames keep arriving into the FIFO during REQ and RESP.

Test Plan:
- Write: frame A5_01_10_DEADBEEF_chk, I_reg_ack returned at request cycle 2 -> O_reg_wr high for exactly 2 cycles with addr 0x10, wdata 0xDEADBEEF; response 5A_81_10_00000000_chk; O_err_cnt = 0.
- Read: frame A5_02_20_00000000_chk, ack with rdata 0x12345678 -> O_reg_rd pulse, then response 5A_82_20_12345678_chk; with I_resp_ready held low 5 cycles, O_resp_data stays stable and only one response is emitted.
- Bad frames: header 0x00, then a wrong checksum, then opcode 0x07 -> no bus request, no response, O_err_cnt = 3.
- Timeout: ACK_TIMEOUT = 8, read with no ack -> O_reg_rd high for 8 cycles, response status 0xFF, rdata 0, O_err_cnt = 1. Separately, ack arriving on the final timeout cycle -> status 0x82.
- Overflow: DEPTH = 4, I_resp_ready = 0, 7 back-to-back frames -> first frame dispatched, 4 buffered, 2 dropped, O_ovf_cnt = 2. Releasing ready yields 5 responses in arrival order.
- Reset: assert I_rst during REQ with 2 frames queued -> all outputs 0 immediately. After release, no response until a new frame arrives.

Source files
------------

// File: rtl/uart_cmd_dispatch.sv
// Frame FIFO + checker + register-bus command executor; request 3 cycles after a frame lands in an idle, empty FIFO.
// Frames arriving while the FIFO is full are dropped and counted; a pending response holds until I_resp_ready.
module uart_cmd_dispatch #(
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        I_clk_10M,
    input  logic        I_rst,
    input  logic [63:0] I_data,
    input  logic        I_data_valid,
    output logic        O_reg_wr,
    output logic        O_reg_rd,
    output logic [7:0]  O_reg_addr,
    output logic [31:0] O_reg_wdata,
    input  logic        I_reg_ack,
    input  logic [31:0] I_reg_rdata,
    output logic [63:0] O_resp_data,
    output logic        O_resp_valid,
    input  logic        I_resp_ready,
    output logic [7:0]  O_err_cnt,
    output logic [7:0]  O_ovf_cnt
);
    localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0]     FULL     = (PW + 1)'(DEPTH);
    localparam logic [15:0]     TMO_LAST = 16'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_REQ, S_RESP} state_t;

    logic [63:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    state_t        state_q, state_d;
    logic [63:0]   frame_q, frame_d;
    logic [7:0]    status_q, status_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [15:0]   tmo_q, tmo_d;
    logic [7:0]    err_q, ovf_q;
    logic          pop, push, err_inc;
    logic [7:0]    op;
    logic [55:0]   resp_head;

    function automatic logic [7:0] xor7(input logic [55:0] b);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 7; i++) x = x ^ b[i*8 +: 8];
        return x;
    endfunction

    assign op        = frame_q[55:48];
    assign pop       = (state_q == S_IDLE) && (count_q != '0);
    // A full FIFO still accepts a frame when the head leaves in the same cycle.
    assign push      = I_data_valid && ((count_q != FULL) || pop);
    assign resp_head = {8'h5A, status_q, frame_q[47:40], rdata_q};

    always_ff @(posedge I_clk_10M) begin
        if (push) mem_q[wr_ptr_q] <= I_data;
    end

    always_ff @(posedge I_clk_10M or posedge I_rst) begin
        if (I_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
            err_q    <= '0;
            state_q  <= S_IDLE;
            frame_q  <= '0;
            status_q <= '0;
            rdata_q  <= '0;
            tmo_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PW + 1)'(1);
                2'b01:   count_q <= count_q - (PW + 1)'(1);
                default: count_q <= count_q;
            endcase
            if (I_data_valid && !push && ovf_q != 8'hFF) ovf_q <= ovf_q + 8'd1;
            if (err_inc && err_q != 8'hFF)               err_q <= err_q + 8'd1;
            state_q  <= state_d;
            frame_q  <= frame_d;
            status_q <= status_d;
            rdata_q  <= rdata_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        status_d     = status_q;
        rdata_d      = rdata_q;
        tmo_d        = tmo_q;
        err_inc      = 1'b0;
        O_reg_wr     = 1'b0;
        O_reg_rd     = 1'b0;
        O_reg_addr   = '0;
        O_reg_wdata  = '0;
        O_resp_valid = 1'b0;
        O_resp_data  = '0;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    frame_d = mem_q[rd_ptr_q];
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                tmo_d = '0;
                if (frame_q[63:56] != 8'hA5 || frame_q[7:0] != xor7(frame_q[63:8]) ||
                    (op != 8'h01 && op != 8'h02)) begin
                    err_inc = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                O_reg_wr    = (op == 8'h01);
                O_reg_rd    = (op == 8'h02);
                O_reg_addr  = frame_q[47:40];
                O_reg_wdata = frame_q[39:8];
                tmo_d       = tmo_q + 16'd1;
                // Ack is checked first so a late ack on the last allowed cycle still succeeds.
                if (I_reg_ack) begin
                    status_d = op | 8'h80;
                    rdata_d  = (op == 8'h02) ? I_reg_rdata : 32'h0;
                    state_d  = S_RESP;
                end else if (tmo_q == TMO_LAST) begin
                    status_d = 8'hFF;
                    rdata_d  = 32'h0;
                    err_inc  = 1'b1;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                O_resp_valid = 1'b1;
                O_resp_data  = {resp_head, xor7(resp_head)};
                if (I_resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign O_err_cnt = err_q;
    assign O_ovf_cnt = ovf_q;
endmodule

// File: tb/tb_uart_cmd_dispatch.sv
// Randomised and directed bench for uart_cmd_dispatch with a bus responder, response monitor and frame-level model.
module tb_uart_cmd_dispatch;
    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic        clk = 1'b0;
    logic        I_rst;
    logic [63:0] I_data;
    logic        I_data_valid;
    logic        O_reg_wr, O_reg_rd;
    logic [7:0]  O_reg_addr;
    logic [31:0] O_reg_wdata;
    logic        I_reg_ack;
    logic [31:0] I_reg_rdata;
    logic [63:0] O_resp_data;
    logic        O_resp_valid, I_resp_ready;
    logic [7:0]  O_err_cnt, O_ovf_cnt;

    always #50 clk = ~clk;

    uart_cmd_dispatch #(.DEPTH(DEPTH), .ACK_TIMEOUT(TMO)) dut (
        .I_clk_10M(clk), .I_rst(I_rst), .I_data(I_data), .I_data_valid(I_data_valid),
        .O_reg_wr(O_reg_wr), .O_reg_rd(O_reg_rd), .O_reg_addr(O_reg_addr), .O_reg_wdata(O_reg_wdata),
        .I_reg_ack(I_reg_ack), .I_reg_rdata(I_reg_rdata), .O_resp_data(O_resp_data),
        .O_resp_valid(O_resp_valid), .I_resp_ready(I_resp_ready),
        .O_err_cnt(O_err_cnt), .O_ovf_cnt(O_ovf_cnt)
    );

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        acked;
        int          dly;
        int          len;
    } txn_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          stab_err = 0;
    int          ack_delay = 0;
    bit          rand_ack  = 0;
    bit          rand_rdy  = 0;
    logic [31:0] ack_rdata = 32'h0;
    txn_t        bus_q[$];
    logic [63:0] resp_q[$];

    // Reference model: frames and responses built straight from the frame-format rules.
    function automatic logic [7:0] xsum(input logic [55:0] b);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < 7; i++) s = s ^ b[i*8 +: 8];
        return s;
    endfunction

    function automatic logic [63:0] mk_frame(input logic [7:0] hdr, input logic [7:0] op,
                                             input logic [7:0] addr, input logic [31:0] pl,
                                             input logic [7:0] chk_flip);
        logic [55:0] b = {hdr, op, addr, pl};
        return {b, xsum(b) ^ chk_flip};
    endfunction

    function automatic bit frame_good(input logic [63:0] f);
        return (f[63:56] == 8'hA5) && (f[55:48] == 8'h01 || f[55:48] == 8'h02) &&
               (f[7:0] == xsum(f[63:8]));
    endfunction

    function automatic bit times_out(input txn_t t);
        return (t.dly < 0) || (t.dly >= TMO);
    endfunction

    function automatic logic [63:0] exp_resp(input logic [63:0] f, input txn_t t);
        logic [7:0]  st;
        logic [31:0] rd;
        logic [55:0] b;
        if (times_out(t)) begin
            st = 8'hFF; rd = 32'h0;
        end else begin
            st = f[55:48] | 8'h80;
            rd = (f[55:48] == 8'h02) ? t.rdata : 32'h0;
        end
        b = {8'h5A, st, f[47:40], rd};
        return {b, xsum(b)};
    endfunction

    function automatic logic [63:0] const_resp(input logic [7:0] st, input logic [7:0] a, input logic [31:0] rd);
        logic [55:0] b = {8'h5A, st, a, rd};
        return {b, xsum(b)};
    endfunction

    // Register-bus responder: acks after a chosen number of request cycles, logs each transaction.
    initial begin
        int   cyc;
        int   dly;
        bit   active;
        txn_t t;
        I_reg_ack = 1'b0; I_reg_rdata = '0; active = 0; cyc = 0; dly = 0;
        t = '{wr: 1'b0, addr: 8'h0, wdata: 32'h0, rdata: 32'h0, acked: 1'b0, dly: 0, len: 0};
        forever begin
            @(negedge clk);
            if (O_reg_wr || O_reg_rd) begin
                if (!active) begin
                    active  = 1; cyc = 0;
                    dly     = rand_ack ? int'($urandom_range(0, 9)) : ack_delay;
                    t.wr    = O_reg_wr;   t.addr = O_reg_addr; t.wdata = O_reg_wdata;
                    t.rdata = rand_ack ? $urandom : ack_rdata;
                    t.acked = 1'b0;       t.dly  = dly;
                end
                t.len = cyc + 1;
                if (cyc == dly) begin
                    I_reg_ack = 1'b1; I_reg_rdata = t.rdata; t.acked = 1'b1;
                end else begin
                    I_reg_ack = 1'b0; I_reg_rdata = $urandom;
                end
                cyc++;
            end else begin
                I_reg_ack = 1'b0; I_reg_rdata = '0;
                if (active) begin bus_q.push_back(t); active = 0; end
            end
        end
    end

    // Response monitor: logs handshakes and flags any change of a pending response.
    initial begin
        logic        pv, phs;
        logic [63:0] pd;
        pv = 1'b0; phs = 1'b0; pd = '0;
        forever begin
            @(negedge clk);
            if (pv && !phs && !I_rst && (!O_resp_valid || O_resp_data !== pd)) stab_err++;
            phs = O_resp_valid && I_resp_ready;
            if (phs) resp_q.push_back(O_resp_data);
            pv = O_resp_valid; pd = O_resp_data;
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_rdy) I_resp_ready = ($urandom_range(0, 1) == 1);
        end
    end

    task automatic send(input logic [63:0] f);
        @(posedge clk); #1; I_data = f; I_data_valid = 1'b1;
        @(posedge clk); #1; I_data_valid = 1'b0;
    endtask

    task automatic wait_resp(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (resp_q.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic do_reset();
        I_rst = 1'b1; I_data_valid = 1'b0; I_resp_ready = 1'b0; rand_ack = 0; rand_rdy = 0; ack_delay = 0;
        repeat (2) @(posedge clk);
        #1; I_rst = 1'b0;
        @(posedge clk); #1;
        bus_q.delete(); resp_q.delete(); stab_err = 0;
    endtask

    task automatic test_reset();
        I_rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({O_reg_wr, O_reg_rd, O_reg_addr, O_reg_wdata} !== '0)
            $display("FAIL reset_bus: got wr=%b rd=%b addr=%h wdata=%h, required all 0", O_reg_wr, O_reg_rd, O_reg_addr, O_reg_wdata);
        else n_pass++;
        n_checks++;
        if ({O_resp_valid, O_resp_data} !== '0)
            $display("FAIL reset_resp: got valid=%b data=%h, required 0", O_resp_valid, O_resp_data);
        else n_pass++;
        n_checks++;
        if ({O_err_cnt, O_ovf_cnt} !== 16'h0)
            $display("FAIL reset_cnt: got err=%0d ovf=%0d, required 0", O_err_cnt, O_ovf_cnt);
        else n_pass++;
        @(posedge clk); #1; I_rst = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if ({O_reg_wr, O_reg_rd, O_resp_valid} !== 3'b000)
            $display("FAIL reset_idle: got wr=%b rd=%b valid=%b, required 000", O_reg_wr, O_reg_rd, O_resp_valid);
        else n_pass++;
    endtask

    task automatic test_latency();
        int n_req, n_resp;
        do_reset();
        I_resp_ready = 1'b1; ack_delay = 0; ack_rdata = 32'h0BADF00D;
        send(mk_frame(8'hA5, 8'h02, 8'h33, 32'h0, 8'h00));
        n_req = 0; n_resp = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (n_req == 0 && O_reg_rd) n_req = i;
            if (O_resp_valid) begin n_resp = i; break; end
        end
        n_checks++;
        if (n_req != 3) $display("FAIL latency_req: got cycle %0d, required 3", n_req); else n_pass++;
        n_checks++;
        if (n_resp != 4) $display("FAIL latency_resp: got cycle %0d, required 4", n_resp); else n_pass++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_write();
        bit ok;
        do_reset();
        I_resp_ready = 1'b1; ack_delay = 1; ack_rdata = 32'h55AA55AA;
        send(mk_frame(8'hA5, 8'h01, 8'h10, 32'hDEADBEEF, 8'h00));
        wait_resp(1, 60, ok);
        repeat (3) @(negedge clk);
        n_checks++;
        if (!ok || resp_q.size() != 1 || bus_q.size() != 1)
            $display("FAIL write_count: got resp=%0d bus=%0d, required 1 and 1", resp_q.size(), bus_q.size());
        else n_pass++;
        if (bus_q.size() > 0) begin
            n_checks++;
            if ({bus_q[0].wr, bus_q[0].addr, bus_q[0].wdata} !== {1'b1, 8'h10, 32'hDEADBEEF} || bus_q[0].len != 2)
                $display("FAIL write_bus: got wr=%b addr=%h wdata=%h len=%0d, required 1 10 deadbeef 2",
                         bus_q[0].wr, bus_q[0].addr, bus_q[0].wdata, bus_q[0].len);
            else n_pass++;
        end
        if (resp_q.size() > 0) begin
            n_checks++;
            if (resp_q[0] !== const_resp(8'h81, 8'h10, 32'h0))
                $display("FAIL write_resp: got %h, required %h", resp_q[0], const_resp(8'h81, 8'h10, 32'h0));
            else n_pass++;
        end
        n_checks++;
        if (O_err_cnt !== 8'd0) $display("FAIL write_err: got %0d, required 0", O_err_cnt); else n_pass++;
    endtask

    task automatic test_read();
        bit ok;
        do_reset();
        I_resp_ready = 1'b0; ack_delay = 0; ack_rdata = 32'h12345678;
        send(mk_frame(8'hA5, 8'h02, 8'h20, 32'h0, 8'h00));
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (O_resp_valid) begin ok = 1; break; end
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (!ok || !O_resp_valid || stab_err != 0)
            $display("FAIL read_hold: got valid=%b seen=%b changes=%0d, required 1 1 0", O_resp_valid, ok, stab_err);
        else n_pass++;
        n_checks++;
        if (O_resp_data !== const_resp(8'h82, 8'h20, 32'h12345678))
            $display("FAIL read_resp: got %h, required %h", O_resp_data, const_resp(8'h82, 8'h20, 32'h12345678));
        else n_pass++;
        @(posedge clk); #1; I_resp_ready = 1'b1;
        @(posedge clk); #1; I_resp_ready = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (resp_q.size() != 1 || O_resp_valid !== 1'b0)
            $display("FAIL read_once: got %0d responses valid=%b, required 1 and 0", resp_q.size(), O_resp_valid);
        else n_pass++;
        n_checks++;
        if (bus_q.size() != 1 || bus_q[0].wr !== 1'b0 || bus_q[0].addr !== 8'h20 || bus_q[0].len != 1)
            $display("FAIL read_bus: got %0d transactions, required one 1-cycle read of 20", bus_q.size());
        else n_pass++;
    endtask

    task automatic test_bad();
        do_reset();
        I_resp_ready = 1'b1; ack_delay = 0;
        send(mk_frame(8'h00, 8'h01, 8'h11, 32'h01020304, 8'h00));
        send(mk_frame(8'hA5, 8'h01, 8'h12, 32'h05060708, 8'h40));
        send(mk_frame(8'hA5, 8'h07, 8'h13, 32'h090A0B0C, 8'h00));
        repeat (20) @(negedge clk);
        n_checks++;
        if (O_err_cnt !== 8'd3) $display("FAIL bad_err: got %0d, required 3", O_err_cnt); else n_pass++;
        n_checks++;
        if (bus_q.size() != 0 || resp_q.size() != 0)
            $display("FAIL bad_quiet: got bus=%0d resp=%0d, required 0 0", bus_q.size(), resp_q.size());
        else n_pass++;
    endtask

    task automatic test_timeout();
        bit ok;
        do_reset();
        I_resp_ready = 1'b1; ack_delay = -1;
        send(mk_frame(8'hA5, 8'h02, 8'h44, 32'h0, 8'h00));
        wait_resp(1, 60, ok);
        repeat (3) @(negedge clk);
        n_checks++;
        if (!ok || bus_q.size() != 1 || bus_q[0].wr !== 1'b0 || bus_q[0].len != TMO)
            $display("FAIL tmo_len: got %0d transactions ok=%b, required one read of %0d cycles", bus_q.size(), ok, TMO);
        else n_pass++;
        n_checks++;
        if (resp_q.size() != 1 || resp_q[0] !== const_resp(8'hFF, 8'h44, 32'h0))
            $display("FAIL tmo_resp: got %0d responses, required one of %h", resp_q.size(), const_resp(8'hFF, 8'h44, 32'h0));
        else n_pass++;
        n_checks++;
        if (O_err_cnt !== 8'd1) $display("FAIL tmo_err: got %0d, required 1", O_err_cnt); else n_pass++;
        bus_q.delete(); resp_q.delete();
        ack_delay = TMO - 1; ack_rdata = 32'hCAFE0001;
        send(mk_frame(8'hA5, 8'h02, 8'h45, 32'h0, 8'h00));
        wait_resp(1, 60, ok);
        repeat (3) @(negedge clk);
        n_checks++;
        if (resp_q.size() != 1 || resp_q[0] !== const_resp(8'h82, 8'h45, 32'hCAFE0001))
            $display("FAIL tmo_late_ack: got %0d responses, required one of %h", resp_q.size(), const_resp(8'h82, 8'h45, 32'hCAFE0001));
        else n_pass++;
        n_checks++;
        if (O_err_cnt !== 8'd1 || bus_q.size() != 1 || bus_q[0].len != TMO)
            $display("FAIL tmo_late_err: got err=%0d bus=%0d, required err 1 and one %0d-cycle request", O_err_cnt, bus_q.size(), TMO);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [63:0] fr [7];
        bit          ok;
        do_reset();
        I_resp_ready = 1'b0; ack_delay = 0; ack_rdata = $urandom;
        for (int i = 0; i < 7; i++) begin
            fr[i] = mk_frame(8'hA5, ($urandom_range(0, 1) == 1) ? 8'h01 : 8'h02,
                             8'($urandom_range(0, 255)), $urandom, 8'h00);
            @(posedge clk); #1; I_data = fr[i]; I_data_valid = 1'b1;
        end
        @(posedge clk); #1; I_data_valid = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (O_ovf_cnt !== 8'd2) $display("FAIL ovf_cnt: got %0d, required 2", O_ovf_cnt); else n_pass++;
        @(posedge clk); #1; I_resp_ready = 1'b1;
        wait_resp(5, 200, ok);
        repeat (20) @(negedge clk);
        n_checks++;
        if (!ok || resp_q.size() != 5 || bus_q.size() != 5)
            $display("FAIL ovf_count: got resp=%0d bus=%0d, required 5 5", resp_q.size(), bus_q.size());
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            if (i < resp_q.size() && i < bus_q.size()) begin
                n_checks++;
                if (resp_q[i] !== exp_resp(fr[i], bus_q[i]) || bus_q[i].addr !== fr[i][47:40])
                    $display("FAIL ovf_order[%0d]: got %h, required %h", i, resp_q[i], exp_resp(fr[i], bus_q[i]));
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        I_resp_ready = 1'b1; ack_delay = -1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; I_data = mk_frame(8'hA5, 8'h02, 8'(8'h60 + i), 32'h0, 8'h00); I_data_valid = 1'b1;
        end
        @(posedge clk); #1; I_data_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (O_reg_rd) begin ok = 1; break; end
        end
        repeat (2) @(negedge clk);
        #10; I_rst = 1'b1;
        #1;
        n_checks++;
        if (!ok || {O_reg_wr, O_reg_rd, O_reg_addr, O_reg_wdata, O_resp_valid, O_resp_data, O_err_cnt, O_ovf_cnt} !== '0)
            $display("FAIL rst_mid_outputs: got rd=%b addr=%h valid=%b err=%0d (req seen=%b), required all 0",
                     O_reg_rd, O_reg_addr, O_resp_valid, O_err_cnt, ok);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1; I_rst = 1'b0;
        @(negedge clk);
        bus_q.delete(); resp_q.delete();
        repeat (40) @(negedge clk);
        n_checks++;
        if (bus_q.size() != 0 || resp_q.size() != 0 || O_err_cnt !== 8'd0)
            $display("FAIL rst_mid_quiet: got bus=%0d resp=%0d err=%0d, required 0 0 0", bus_q.size(), resp_q.size(), O_err_cnt);
        else n_pass++;
        ack_delay = 0; ack_rdata = 32'h00C0FFEE;
        send(mk_frame(8'hA5, 8'h02, 8'h70, 32'h0, 8'h00));
        wait_resp(1, 60, ok);
        n_checks++;
        if (!ok || resp_q[0] !== const_resp(8'h82, 8'h70, 32'h00C0FFEE))
            $display("FAIL rst_mid_new: got ok=%b resp=%h, required %h", ok, ok ? resp_q[0] : 64'h0, const_resp(8'h82, 8'h70, 32'h00C0FFEE));
        else n_pass++;
    endtask

    task automatic test_random();
        logic [63:0] good_q[$];
        logic [63:0] f;
        logic [7:0]  hdr, op, flip;
        int          n_bad, sent, pend, n_tmo;
        bit          ok;
        do_reset();
        rand_ack = 1; rand_rdy = 1; n_bad = 0; sent = 0;
        for (int i = 0; i < 40; i++) begin
            ok = 0;
            for (int w = 0; w < 2000; w++) begin
                n_tmo = 0;
                foreach (bus_q[k]) if (!bus_q[k].acked) n_tmo++;
                pend = sent - resp_q.size() - (int'(O_err_cnt) - n_tmo);
                if (pend < DEPTH - 1) begin ok = 1; break; end
                @(posedge clk); #1;
            end
            if (!ok) begin
                n_checks++;
                $display("FAIL rand_stall: frame %0d never admitted, pending=%0d", i, pend);
                break;
            end
            hdr = 8'hA5; flip = 8'h00;
            op  = ($urandom_range(0, 1) == 1) ? 8'h01 : 8'h02;
            case ($urandom_range(0, 9))
                0: hdr  = 8'($urandom_range(0, 164));
                1: flip = 8'($urandom_range(1, 255));
                2: op   = 8'($urandom_range(3, 255));
                default: ;
            endcase
            f = mk_frame(hdr, op, 8'($urandom_range(0, 255)), $urandom, flip);
            if (frame_good(f)) good_q.push_back(f); else n_bad++;
            send(f);
            sent++;
            repeat ($urandom_range(0, 4)) @(posedge clk);
        end
        wait_resp(good_q.size(), 3000, ok);
        rand_rdy = 0; I_resp_ready = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (!ok || resp_q.size() != good_q.size() || bus_q.size() != good_q.size())
            $display("FAIL rand_count: got resp=%0d bus=%0d, required %0d", resp_q.size(), bus_q.size(), good_q.size());
        else n_pass++;
        n_tmo = 0;
        for (int i = 0; i < good_q.size() && i < resp_q.size() && i < bus_q.size(); i++) begin
            if (times_out(bus_q[i])) n_tmo++;
            n_checks++;
            if (bus_q[i].wr !== (good_q[i][55:48] == 8'h01) || bus_q[i].addr !== good_q[i][47:40] ||
                bus_q[i].wdata !== good_q[i][39:8] || bus_q[i].len != (times_out(bus_q[i]) ? TMO : bus_q[i].dly + 1))
                $display("FAIL rand_bus[%0d]: got wr=%b addr=%h wdata=%h len=%0d, frame %h", i,
                         bus_q[i].wr, bus_q[i].addr, bus_q[i].wdata, bus_q[i].len, good_q[i]);
            else n_pass++;
            n_checks++;
            if (resp_q[i] !== exp_resp(good_q[i], bus_q[i]))
                $display("FAIL rand_resp[%0d]: got %h, required %h", i, resp_q[i], exp_resp(good_q[i], bus_q[i]));
            else n_pass++;
        end
        n_checks++;
        if (O_err_cnt !== 8'(n_bad + n_tmo) || O_ovf_cnt !== 8'd0)
            $display("FAIL rand_counters: got err=%0d ovf=%0d, required err=%0d ovf=0", O_err_cnt, O_ovf_cnt, n_bad + n_tmo);
        else n_pass++;
        rand_ack = 0;
    endtask

    initial begin
        I_rst = 1'b1; I_data = '0; I_data_valid = 1'b0; I_resp_ready = 1'b0;
        test_reset();
        test_latency();
        test_write();
        test_read();
        test_bad();
        test_timeout();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
